// File: rtl/tlp_asm_pkg.sv
// Shared defaults, state encodings and helpers for the TLP packet assembler.
package tlp_asm_pkg;

    localparam int unsigned TLP_WORDS_DEF = 15;
    localparam logic [7:0]  HDR_TAG_DEF   = 8'hA5;

    typedef enum logic [1:0] {IDLE, HDR, DATA} out_state_t;
    typedef enum logic [1:0] {ACCEPT_WAIT, ACCEPT, DROP, RESYNC} in_state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/tlp_sync_fifo.sv
// Show-ahead synchronous FIFO; pushes when full and pops when empty are ignored.
module tlp_sync_fifo #(
    parameter int unsigned WIDTH = 40,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    always_comb begin
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty    = (wr_ptr_q == rd_ptr_q);
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        dout     = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/tlp_packet_assembler.sv
// Buffers packer output, admits whole packets only, and streams header + data beats
// toward the DMA engine on a valid/ready interface.
module tlp_packet_assembler
    import tlp_asm_pkg::*;
#(
    parameter int unsigned TLP_WORDS  = TLP_WORDS_DEF,
    parameter int unsigned DATA_DEPTH = 64,
    parameter int unsigned HDR_DEPTH  = 4,
    parameter logic [7:0]  HDR_TAG    = HDR_TAG_DEF
) (
    input  logic                          InputClock,
    input  logic                          rst,
    input  logic [63:0]                   TLPData,
    input  logic [39:0]                   TLPHeader,
    input  logic                          DataWriteEnable,
    input  logic                          HeaderWriteEnable,
    output logic [63:0]                   PktData,
    output logic                          PktValid,
    output logic                          PktSop,
    output logic                          PktEop,
    input  logic                          PktReady,
    output logic [15:0]                   DropCount,
    output logic [15:0]                   FrameErrCount,
    output logic [$clog2(DATA_DEPTH):0]   Level
);
    localparam int unsigned AW = $clog2(DATA_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned IW = $clog2(TLP_WORDS + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(TLP_WORDS - 1);

    logic [63:0]   data_mem_q [DATA_DEPTH];

    in_state_t     in_state_q, in_state_d;
    logic [IW-1:0] wr_idx_q, wr_idx_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] pkt_start_q, pkt_start_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;
    logic [15:0]   ferr_cnt_q, ferr_cnt_d;
    logic [PW-1:0] level_q, level_d;

    out_state_t    out_state_q, out_state_d;
    logic [63:0]   pkt_data_q, pkt_data_d;
    logic          pkt_valid_q, pkt_valid_d;
    logic          pkt_sop_q, pkt_sop_d;
    logic          pkt_eop_q, pkt_eop_d;
    logic [IW-1:0] out_idx_q, out_idx_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;

    logic          mem_we, hdr_push, hdr_pop, hdr_full, hdr_empty;
    logic [39:0]   hdr_dout;
    logic          last_word, admit, accepting;
    logic [PW-1:0] free_words, rd_next;
    logic [IW-1:0] out_idx_inc;

    tlp_sync_fifo #(.WIDTH(40), .DEPTH(HDR_DEPTH)) u_hdr_fifo (
        .clk   (InputClock),
        .rst   (rst),
        .push  (hdr_push),
        .din   (TLPHeader),
        .pop   (hdr_pop),
        .dout  (hdr_dout),
        .full  (hdr_full),
        .empty (hdr_empty)
    );

    // Input side: pkt_start always equals wr_ptr between packets, so rollback is safe at any wr_idx.
    always_comb begin
        in_state_d  = in_state_q;
        wr_idx_d    = wr_idx_q;
        wr_ptr_d    = wr_ptr_q;
        pkt_start_d = pkt_start_q;
        drop_cnt_d  = drop_cnt_q;
        ferr_cnt_d  = ferr_cnt_q;
        mem_we      = 1'b0;
        hdr_push    = 1'b0;
        last_word   = (wr_idx_q == LAST_IDX);
        free_words  = PW'(DATA_DEPTH) - (wr_ptr_q - rd_ptr_q);
        admit       = (free_words >= PW'(TLP_WORDS)) && !hdr_full;
        accepting   = (in_state_q == ACCEPT) || ((in_state_q == ACCEPT_WAIT) && admit);

        if (in_state_q == RESYNC) begin
            if (HeaderWriteEnable) begin
                in_state_d = ACCEPT_WAIT;
                wr_idx_d   = '0;
            end
        end else if (HeaderWriteEnable && (!DataWriteEnable || !last_word)) begin
            ferr_cnt_d = sat_inc(ferr_cnt_q);
            wr_ptr_d   = pkt_start_q;
            wr_idx_d   = '0;
            in_state_d = ACCEPT_WAIT;
        end else if (DataWriteEnable) begin
            if (last_word && !HeaderWriteEnable) begin
                ferr_cnt_d = sat_inc(ferr_cnt_q);
                wr_ptr_d   = pkt_start_q;
                wr_idx_d   = '0;
                in_state_d = RESYNC;
            end else begin
                if (accepting) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                end
                if (last_word) begin
                    if (accepting) hdr_push = 1'b1;
                    else           drop_cnt_d = sat_inc(drop_cnt_q);
                    wr_idx_d    = '0;
                    in_state_d  = ACCEPT_WAIT;
                    pkt_start_d = wr_ptr_d;
                end else begin
                    wr_idx_d   = wr_idx_q + 1'b1;
                    in_state_d = accepting ? ACCEPT : DROP;
                end
            end
        end
    end

    always_comb begin
        out_state_d = out_state_q;
        pkt_data_d  = pkt_data_q;
        pkt_valid_d = pkt_valid_q;
        pkt_sop_d   = pkt_sop_q;
        pkt_eop_d   = pkt_eop_q;
        out_idx_d   = out_idx_q;
        rd_ptr_d    = rd_ptr_q;
        hdr_pop     = 1'b0;
        rd_next     = rd_ptr_q + 1'b1;
        out_idx_inc = out_idx_q + 1'b1;

        case (out_state_q)
            IDLE: begin
                if (!hdr_empty) begin
                    pkt_data_d  = {HDR_TAG, 16'h0, hdr_dout};
                    pkt_valid_d = 1'b1;
                    pkt_sop_d   = 1'b1;
                    pkt_eop_d   = 1'b0;
                    out_state_d = HDR;
                end
            end
            HDR: begin
                if (PktReady) begin
                    hdr_pop     = 1'b1;
                    pkt_data_d  = data_mem_q[rd_ptr_q[AW-1:0]];
                    pkt_sop_d   = 1'b0;
                    pkt_eop_d   = (LAST_IDX == '0);
                    out_idx_d   = '0;
                    out_state_d = DATA;
                end
            end
            DATA: begin
                if (PktReady) begin
                    rd_ptr_d = rd_next;
                    if (out_idx_q == LAST_IDX) begin
                        pkt_eop_d = 1'b0;
                        if (!hdr_empty) begin
                            pkt_data_d  = {HDR_TAG, 16'h0, hdr_dout};
                            pkt_sop_d   = 1'b1;
                            out_state_d = HDR;
                        end else begin
                            pkt_valid_d = 1'b0;
                            pkt_sop_d   = 1'b0;
                            out_state_d = IDLE;
                        end
                    end else begin
                        out_idx_d  = out_idx_inc;
                        pkt_data_d = data_mem_q[rd_next[AW-1:0]];
                        pkt_eop_d  = (out_idx_inc == LAST_IDX);
                    end
                end
            end
            default: out_state_d = IDLE;
        endcase

        level_d = wr_ptr_d - rd_ptr_d;
    end

    always_ff @(posedge InputClock) begin
        if (rst) begin
            in_state_q  <= ACCEPT_WAIT;
            wr_idx_q    <= '0;
            wr_ptr_q    <= '0;
            pkt_start_q <= '0;
            drop_cnt_q  <= '0;
            ferr_cnt_q  <= '0;
            level_q     <= '0;
            out_state_q <= IDLE;
            pkt_data_q  <= '0;
            pkt_valid_q <= 1'b0;
            pkt_sop_q   <= 1'b0;
            pkt_eop_q   <= 1'b0;
            out_idx_q   <= '0;
            rd_ptr_q    <= '0;
        end else begin
            in_state_q  <= in_state_d;
            wr_idx_q    <= wr_idx_d;
            wr_ptr_q    <= wr_ptr_d;
            pkt_start_q <= pkt_start_d;
            drop_cnt_q  <= drop_cnt_d;
            ferr_cnt_q  <= ferr_cnt_d;
            level_q     <= level_d;
            out_state_q <= out_state_d;
            pkt_data_q  <= pkt_data_d;
            pkt_valid_q <= pkt_valid_d;
            pkt_sop_q   <= pkt_sop_d;
            pkt_eop_q   <= pkt_eop_d;
            out_idx_q   <= out_idx_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    always_ff @(posedge InputClock) begin
        if (mem_we) data_mem_q[wr_ptr_q[AW-1:0]] <= TLPData;
    end

    assign PktData       = pkt_data_q;
    assign PktValid      = pkt_valid_q;
    assign PktSop        = pkt_sop_q;
    assign PktEop        = pkt_eop_q;
    assign DropCount     = drop_cnt_q;
    assign FrameErrCount = ferr_cnt_q;
    assign Level         = level_q;

endmodule

// File: tb/tb_tlp_packet_assembler.sv
// Scoreboard bench: stimulus pushes expected beats, a monitor pops them on each handshake.
module tb_tlp_packet_assembler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] TLPData = '0;
    logic [39:0] TLPHeader = '0;
    logic        DataWriteEnable = 1'b0;
    logic        HeaderWriteEnable = 1'b0;
    logic [63:0] PktData;
    logic        PktValid, PktSop, PktEop;
    logic        PktReady = 1'b0;
    logic [15:0] DropCount, FrameErrCount;
    logic [6:0]  Level;

    int n_checks = 0;
    int n_fail = 0;
    int exp_drop = 0;
    int exp_ferr = 0;
    int ready_mode = 1;  // 0 low, 1 high, 2 random
    int beats_seen = 0;
    logic [65:0] sb [$];  // {sop, eop, data}

    always #5 clk = ~clk;

    tlp_packet_assembler #(
        .TLP_WORDS (15),
        .DATA_DEPTH(64),
        .HDR_DEPTH (4),
        .HDR_TAG   (8'hA5)
    ) dut (
        .InputClock       (clk),
        .rst              (rst),
        .TLPData          (TLPData),
        .TLPHeader        (TLPHeader),
        .DataWriteEnable  (DataWriteEnable),
        .HeaderWriteEnable(HeaderWriteEnable),
        .PktData          (PktData),
        .PktValid         (PktValid),
        .PktSop           (PktSop),
        .PktEop           (PktEop),
        .PktReady         (PktReady),
        .DropCount        (DropCount),
        .FrameErrCount    (FrameErrCount),
        .Level            (Level)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       PktReady = 1'b0;
                1:       PktReady = 1'b1;
                default: PktReady = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    initial begin
        logic [65:0] prev, cur, e;
        bit stalled;
        stalled = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = {PktSop, PktEop, PktData};
            if (rst) begin
                stalled = 1'b0;
            end else begin
                if (stalled && PktValid) check("stall_hold", cur, prev);
                if (PktValid && PktReady) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_beat: got 0x%0h, expected no beat", cur);
                    end else begin
                        e = sb.pop_front();
                        check("beat", cur, e);
                        beats_seen++;
                    end
                    stalled = 1'b0;
                end else begin
                    stalled = PktValid;
                    prev = cur;
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached, expected test completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [63:0] d, input bit de, input bit he, input logic [39:0] h);
        TLPData = d;
        DataWriteEnable = de;
        HeaderWriteEnable = he;
        TLPHeader = h;
        tick();
        DataWriteEnable = 1'b0;
        HeaderWriteEnable = 1'b0;
    endtask

    task automatic send_good(input logic [39:0] h, input bit expect_ok, input bit gaps, input bit seq);
        logic [63:0] w [15];
        for (int i = 0; i < 15; i++) w[i] = seq ? 64'(i + 1) : {$urandom, $urandom};
        if (expect_ok) begin
            sb.push_back({1'b1, 1'b0, 8'hA5, 16'h0, h});
            for (int i = 0; i < 15; i++) sb.push_back({1'b0, (i == 14), w[i]});
        end else begin
            exp_drop++;
        end
        for (int i = 0; i < 15; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) send_word('0, 1'b0, 1'b0, '0);
            send_word(w[i], 1'b1, (i == 14), h);
        end
    endtask

    task automatic send_short(input int n);
        for (int i = 0; i < n; i++) send_word({$urandom, $urandom}, 1'b1, (i == n - 1), 40'(i));
        exp_ferr++;
    endtask

    task automatic send_missing(input int extra);
        for (int i = 0; i < 15 + extra; i++) send_word({$urandom, $urandom}, 1'b1, 1'b0, '0);
        send_word({$urandom, $urandom}, 1'b1, 1'b1, 40'h1234);
        exp_ferr++;
    endtask

    task automatic wait_drain(input string tag);
        int c;
        c = 0;
        while ((sb.size() != 0 || PktValid) && c < 3000) begin
            tick();
            c++;
        end
        if (sb.size() != 0 || PktValid) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_drain: %0d beats still pending, expected 0", tag, sb.size());
        end
        tick();
        tick();
    endtask

    task automatic check_state(input string tag, input int exp_level);
        @(negedge clk);
        check({tag, "_level"}, Level, 7'(exp_level));
        check({tag, "_drop"}, DropCount, 16'(exp_drop));
        check({tag, "_ferr"}, FrameErrCount, 16'(exp_ferr));
        tick();
    endtask

    task automatic wait_sop(input string tag);
        int c;
        c = 0;
        @(negedge clk);
        while (!(PktValid && PktSop) && c < 200) begin
            @(negedge clk);
            c++;
        end
        if (!(PktValid && PktSop)) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_sop_timeout: valid=%0b sop=%0b, expected 1 1", tag, PktValid, PktSop);
        end
    endtask

    initial begin
        int b0, t;
        rst = 1'b1;
        ready_mode = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {PktValid, PktSop, PktEop}, 3'b000);
        check("reset_data", PktData, 64'h0);
        check("reset_level", Level, 7'd0);
        check("reset_counters", {DropCount, FrameErrCount}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // 1: single packet, header-to-valid latency
        send_good(40'h00010002FF, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        check("t1_valid_edgeN", PktValid, 1'b0);
        @(negedge clk);
        check("t1_sop_edgeN1", {PktValid, PktSop}, 2'b11);
        wait_drain("t1");
        check_state("t1", 0);

        // 2: backpressure fills the store, fifth packet dropped
        ready_mode = 0;
        tick();
        tick();
        b0 = beats_seen;
        for (int p = 0; p < 4; p++) send_good({$urandom, 8'(p)}, 1'b1, 1'b0, 1'b0);
        send_good(40'hDEAD, 1'b0, 1'b0, 1'b0);
        check_state("t2_full", 60);
        ready_mode = 1;
        wait_drain("t2");
        check("t2_beats", beats_seen - b0, 64);
        check_state("t2_after", 0);

        // 3: short packet
        send_short(10);
        check_state("t3", 0);
        send_good(40'h3333, 1'b1, 1'b0, 1'b0);
        wait_drain("t3");

        // 4: missing header followed by resync
        send_missing(3);
        check_state("t4", 0);
        send_good(40'h4444, 1'b1, 1'b0, 1'b0);
        wait_drain("t4");
        check_state("t4_after", 0);

        // 5: back-to-back packets with no gap
        fork
            begin
                send_good(40'h5551, 1'b1, 1'b0, 1'b0);
                send_good(40'h5552, 1'b1, 1'b0, 1'b0);
            end
            begin
                int good;
                good = 0;
                wait_sop("t5");
                for (int k = 0; k < 32; k++) begin
                    if (PktValid && PktSop == (k % 16 == 0) && PktEop == (k % 16 == 15)) good++;
                    @(negedge clk);
                end
                check("t5_b2b_beats", good, 32);
            end
        join
        wait_drain("t5");

        // random mix under random backpressure
        ready_mode = 2;
        for (int n = 0; n < 40; n++) begin
            t = $urandom_range(0, 9);
            if (t <= 5) begin
                int c;
                c = 0;
                while (sb.size() > 16 && c < 3000) begin
                    tick();
                    c++;
                end
                if (sb.size() > 16) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rand_backlog: %0d beats pending, expected <= 16", sb.size());
                end
                send_good({$urandom, 8'(n)}, 1'b1, 1'b1, 1'b0);
            end else if (t <= 7) begin
                send_short($urandom_range(1, 14));
            end else if (t == 8) begin
                send_missing($urandom_range(0, 4));
            end else begin
                send_word('0, 1'b0, 1'b1, 40'hBAD);
                exp_ferr++;
            end
            repeat ($urandom_range(0, 2)) tick();
        end
        ready_mode = 1;
        wait_drain("rand");
        check_state("rand", 0);

        // 6: reset during beat 5
        send_good(40'h6666, 1'b1, 1'b0, 1'b0);
        wait_sop("t6");
        repeat (5) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        exp_drop = 0;
        exp_ferr = 0;
        @(negedge clk);
        check("t6_valid", PktValid, 1'b0);
        check("t6_level", Level, 7'd0);
        check("t6_counters", {DropCount, FrameErrCount}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        send_good(40'h6667, 1'b1, 1'b0, 1'b0);
        wait_drain("t6");
        check_state("t6_after", 0);

        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
